mbist_mem_responder: RTL and testbench

- Memory-under-test responder for the MBIST engine: the far end of the TAS/TCS/TDS test bus.
- In test mode it decodes address (TAS), operation (TCS) and write data (TDS), performs the access on an internal array, and returns read data with one cycle of latency.
- In functional mode it serves a simple functional port instead.
- A programmable fault table injects stuck-at, transition and coupling faults, so BIST march sequences and pass/fail detection can be checked against known-bad memories.

---
 rtl/mbist_mem_pkg.sv | 28 ++
 rtl/mbist_fault_table.sv | 128 ++++++++++++
 rtl/mbist_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_mbist_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_mem_pkg.sv
// mbist_mem_pkg: shared encodings for the MBIST memory responder.
//   op_e    - test-bus / functional operation codes (bit0 = read, bit1 = write)
//   ft_e    - fault-table entry types (codes 6 and 7 behave as FT_NONE)
//   state_e - responder FSM states
package mbist_mem_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RDWR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    FT_NONE   = 3'd0,
    FT_SA0    = 3'd1,
    FT_SA1    = 3'd2,
    FT_TF_UP  = 3'd3,
    FT_TF_DN  = 3'd4,
    FT_CF_INV = 3'd5
  } ft_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mbist_fault_table.sv
// mbist_fault_table: NF programmable fault entries plus the combinational
// write-side and read-side fault transforms.
//   clk, rst                 - clock, synchronous active-high reset (entries -> NONE)
//   flt_we/idx/type/addr/bit/aggr - entry write port, takes effect next cycle
//   wr_addr, wr_old, wr_new  - address, current contents and data of a write
//   wr_data                  - value to store after SA/TF faults
//   cf_hit, cf_addr, cf_mask - coupling-fault victim update for the same edge
//   rd_addr, rd_raw, rd_data - read address, raw array word, word after SA faults
module mbist_fault_table
  import mbist_mem_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int NF = 4,
  parameter int IW = $clog2(NF),
  parameter int BW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flt_we,
  input  logic [IW-1:0] flt_idx,
  input  logic [2:0]    flt_type,
  input  logic [AW-1:0] flt_addr,
  input  logic [BW-1:0] flt_bit,
  input  logic [AW-1:0] flt_aggr,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_old,
  input  logic [DW-1:0] wr_new,
  output logic [DW-1:0] wr_data,
  output logic          cf_hit,
  output logic [AW-1:0] cf_addr,
  output logic [DW-1:0] cf_mask,
  input  logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_raw,
  output logic [DW-1:0] rd_data
);

  logic [2:0]    ft_type_r [NF];
  logic [AW-1:0] ft_addr_r [NF];
  logic [BW-1:0] ft_bit_r  [NF];
  logic [AW-1:0] ft_aggr_r [NF];

  logic [DW-1:0] wr_data_s;
  logic [NF-1:0] cf_fire_s;
  logic          cf_hit_s;
  logic [AW-1:0] cf_addr_s;
  logic [DW-1:0] cf_mask_s;
  logic [DW-1:0] rd_data_s;

  // Fault entry registers; writable in any FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NF; i++) begin
        ft_type_r[i] <= FT_NONE;
        ft_addr_r[i] <= {AW{1'b0}};
        ft_bit_r[i]  <= {BW{1'b0}};
        ft_aggr_r[i] <= {AW{1'b0}};
      end
    end else if (flt_we) begin
      ft_type_r[flt_idx] <= flt_type;
      ft_addr_r[flt_idx] <= flt_addr;
      ft_bit_r[flt_idx]  <= flt_bit;
      ft_aggr_r[flt_idx] <= flt_aggr;
    end
  end

  // Write transform; entries are applied in ascending order so the highest index wins.
  // TF_UP blocks 0->1 (result = new & old); TF_DN blocks 1->0 (result = new | old).
  always_comb begin
    wr_data_s = wr_new;
    for (int i = 0; i < NF; i++) begin
      case (ft_type_r[i])
        FT_SA0:   wr_data_s[ft_bit_r[i]] = (ft_addr_r[i] == wr_addr) ? 1'b0 : wr_data_s[ft_bit_r[i]];
        FT_SA1:   wr_data_s[ft_bit_r[i]] = (ft_addr_r[i] == wr_addr) ? 1'b1 : wr_data_s[ft_bit_r[i]];
        FT_TF_UP: wr_data_s[ft_bit_r[i]] = (ft_addr_r[i] == wr_addr) ?
                    (wr_data_s[ft_bit_r[i]] & wr_old[ft_bit_r[i]]) : wr_data_s[ft_bit_r[i]];
        FT_TF_DN: wr_data_s[ft_bit_r[i]] = (ft_addr_r[i] == wr_addr) ?
                    (wr_data_s[ft_bit_r[i]] | wr_old[ft_bit_r[i]]) : wr_data_s[ft_bit_r[i]];
        default:  wr_data_s = wr_data_s;
      endcase
    end
  end

  // Coupling entries fire when the aggressor bit actually changes in the stored word.
  always_comb begin
    cf_fire_s = {NF{1'b0}};
    for (int i = 0; i < NF; i++) begin
      cf_fire_s[i] = (ft_type_r[i] == FT_CF_INV) && (ft_aggr_r[i] == wr_addr) &&
                     (ft_aggr_r[i] != ft_addr_r[i]) &&
                     (wr_old[ft_bit_r[i]] != wr_data_s[ft_bit_r[i]]);
    end
  end

  // Only one victim word can be updated per edge: the highest firing entry picks it,
  // and every firing entry on that same word contributes its bit to the inversion mask.
  always_comb begin
    cf_hit_s  = 1'b0;
    cf_addr_s = {AW{1'b0}};
    cf_mask_s = {DW{1'b0}};
    for (int i = 0; i < NF; i++) begin
      cf_hit_s  = cf_hit_s | cf_fire_s[i];
      cf_addr_s = cf_fire_s[i] ? ft_addr_r[i] : cf_addr_s;
    end
    for (int i = 0; i < NF; i++) begin
      cf_mask_s[ft_bit_r[i]] = cf_mask_s[ft_bit_r[i]] ^
                               (cf_fire_s[i] && (ft_addr_r[i] == cf_addr_s));
    end
  end

  // Read transform: only stuck-at faults are visible on the output path.
  always_comb begin
    rd_data_s = rd_raw;
    for (int i = 0; i < NF; i++) begin
      case (ft_type_r[i])
        FT_SA0:  rd_data_s[ft_bit_r[i]] = (ft_addr_r[i] == rd_addr) ? 1'b0 : rd_data_s[ft_bit_r[i]];
        FT_SA1:  rd_data_s[ft_bit_r[i]] = (ft_addr_r[i] == rd_addr) ? 1'b1 : rd_data_s[ft_bit_r[i]];
        default: rd_data_s = rd_data_s;
      endcase
    end
  end

  assign wr_data = wr_data_s;
  assign cf_hit  = cf_hit_s;
  assign cf_addr = cf_addr_s;
  assign cf_mask = cf_mask_s;
  assign rd_data = rd_data_s;

endmodule

// File: rtl/mbist_mem_responder.sv
// mbist_mem_responder: memory-under-test at the far end of the TAS/TCS/TDS bus.
// After reset it sweeps zeros through the array (busy_out=1), then serves one op
// per cycle from the BIST port (test_en_in=1) or the functional port, with
// one-cycle read latency and fault injection from mbist_fault_table.
//   clk, rst            - clock, synchronous active-high reset
//   test_en_in          - port select, sampled every cycle
//   tas_in/tcs_in/tds_in - BIST address / op / write data
//   fn_addr_in, fn_re_in, fn_we_in, fn_data_in - functional port (re+we = RDWR)
//   flt_*_in            - fault-table write port
//   mem_data_out, mem_vld_out - registered read data and one-cycle valid
//   busy_out            - initialisation sweep in progress
//   rd_cnt_out, wr_cnt_out - saturating read / write counters
module mbist_mem_responder
  import mbist_mem_pkg::*;
#(
  parameter int AW   = 8,
  parameter int DW   = 8,
  parameter int NF   = 4,
  parameter int CNTW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  test_en_in,
  input  logic [AW-1:0]         tas_in,
  input  logic [1:0]            tcs_in,
  input  logic [DW-1:0]         tds_in,
  input  logic [AW-1:0]         fn_addr_in,
  input  logic                  fn_re_in,
  input  logic                  fn_we_in,
  input  logic [DW-1:0]         fn_data_in,
  input  logic                  flt_we_in,
  input  logic [$clog2(NF)-1:0] flt_idx_in,
  input  logic [2:0]            flt_type_in,
  input  logic [AW-1:0]         flt_addr_in,
  input  logic [$clog2(DW)-1:0] flt_bit_in,
  input  logic [AW-1:0]         flt_aggr_in,
  output logic [DW-1:0]         mem_data_out,
  output logic                  mem_vld_out,
  output logic                  busy_out,
  output logic [CNTW-1:0]       rd_cnt_out,
  output logic [CNTW-1:0]       wr_cnt_out
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_e          state_r, next_state_s;
  logic [AW-1:0]   init_addr_r;
  logic            busy_r, vld_r;
  logic [DW-1:0]   data_r;
  logic [CNTW-1:0] rd_cnt_r, wr_cnt_r;
  logic [DW-1:0]   mem_r [DEPTH];

  logic [1:0]      op_s;
  logic [AW-1:0]   addr_s, cf_addr_s;
  logic [DW-1:0]   wdata_s, raw_s, stored_s, rd_fault_s, cf_mask_s;
  logic            cf_hit_s, do_rd_s, do_wr_s;

  // Port select: the functional strobes map directly onto the op encoding {we, re}.
  always_comb begin
    if (test_en_in) begin
      op_s    = tcs_in;
      addr_s  = tas_in;
      wdata_s = tds_in;
    end else begin
      op_s    = {fn_we_in, fn_re_in};
      addr_s  = fn_addr_in;
      wdata_s = fn_data_in;
    end
  end

  assign raw_s   = mem_r[addr_s];
  assign do_rd_s = (state_r == ST_RUN) && ((op_s == OP_RD) || (op_s == OP_RDWR));
  assign do_wr_s = (state_r == ST_RUN) && ((op_s == OP_WR) || (op_s == OP_RDWR));

  mbist_fault_table #(
    .AW(AW), .DW(DW), .NF(NF)
  ) u_fault_table (
    .clk      (clk),
    .rst      (rst),
    .flt_we   (flt_we_in),
    .flt_idx  (flt_idx_in),
    .flt_type (flt_type_in),
    .flt_addr (flt_addr_in),
    .flt_bit  (flt_bit_in),
    .flt_aggr (flt_aggr_in),
    .wr_addr  (addr_s),
    .wr_old   (raw_s),
    .wr_new   (wdata_s),
    .wr_data  (stored_s),
    .cf_hit   (cf_hit_s),
    .cf_addr  (cf_addr_s),
    .cf_mask  (cf_mask_s),
    .rd_addr  (addr_s),
    .rd_raw   (raw_s),
    .rd_data  (rd_fault_s)
  );

  // Next-state logic: INIT ends after the last address is cleared; RUN is terminal.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_INIT: next_state_s = (init_addr_r == {AW{1'b1}}) ? ST_RUN : ST_INIT;
      ST_RUN:  next_state_s = ST_RUN;
      default: next_state_s = ST_INIT;
    endcase
  end

  // State register, sweep address and busy flag (busy drops on the RUN transition edge).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_INIT;
      init_addr_r <= {AW{1'b0}};
      busy_r      <= 1'b1;
    end else begin
      state_r     <= next_state_s;
      init_addr_r <= (state_r == ST_INIT) ? (init_addr_r + {{(AW-1){1'b0}}, 1'b1}) : init_addr_r;
      busy_r      <= (next_state_s == ST_INIT);
    end
  end

  // Read data, valid pulse and saturating access counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r    <= 1'b0;
      data_r   <= {DW{1'b0}};
      rd_cnt_r <= {CNTW{1'b0}};
      wr_cnt_r <= {CNTW{1'b0}};
    end else begin
      vld_r <= do_rd_s;
      if (do_rd_s) begin
        data_r <= rd_fault_s;
      end
      if (do_rd_s && (rd_cnt_r != CNT_MAX)) begin
        rd_cnt_r <= rd_cnt_r + CNT_ONE;
      end
      if (do_wr_s && (wr_cnt_r != CNT_MAX)) begin
        wr_cnt_r <= wr_cnt_r + CNT_ONE;
      end
    end
  end

  // Array: zero sweep in INIT; in RUN the op's write plus an optional coupling-victim flip.
  // The victim never equals the written address, so the two updates cannot collide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_r == ST_INIT) begin
        mem_r[init_addr_r] <= {DW{1'b0}};
      end else if (do_wr_s) begin
        mem_r[addr_s] <= stored_s;
        if (cf_hit_s) begin
          mem_r[cf_addr_s] <= mem_r[cf_addr_s] ^ cf_mask_s;
        end
      end
    end
  end

  assign mem_data_out = data_r;
  assign mem_vld_out  = vld_r;
  assign busy_out     = busy_r;
  assign rd_cnt_out   = rd_cnt_r;
  assign wr_cnt_out   = wr_cnt_r;

endmodule

// File: tb/tb_mbist_mem_responder.sv
// Self-checking bench for mbist_mem_responder: directed vector table, hand-written
// fault / port-switch / reset sequences, and randomized ops against a reference model.
module tb_mbist_mem_responder;

  localparam int AW = 8, DW = 8, NF = 4, CNTW = 16;

  logic           clk = 1'b0;
  logic           rst, test_en_in;
  logic [AW-1:0]  tas_in, fn_addr_in, flt_addr_in, flt_aggr_in;
  logic [1:0]     tcs_in, flt_idx_in;
  logic [DW-1:0]  tds_in, fn_data_in, mem_data_out;
  logic           fn_re_in, fn_we_in, flt_we_in, mem_vld_out, busy_out;
  logic [2:0]     flt_type_in, flt_bit_in;
  logic [CNTW-1:0] rd_cnt_out, wr_cnt_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mbist_mem_responder #(.AW(AW), .DW(DW), .NF(NF), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .test_en_in(test_en_in),
    .tas_in(tas_in), .tcs_in(tcs_in), .tds_in(tds_in),
    .fn_addr_in(fn_addr_in), .fn_re_in(fn_re_in), .fn_we_in(fn_we_in), .fn_data_in(fn_data_in),
    .flt_we_in(flt_we_in), .flt_idx_in(flt_idx_in), .flt_type_in(flt_type_in),
    .flt_addr_in(flt_addr_in), .flt_bit_in(flt_bit_in), .flt_aggr_in(flt_aggr_in),
    .mem_data_out(mem_data_out), .mem_vld_out(mem_vld_out), .busy_out(busy_out),
    .rd_cnt_out(rd_cnt_out), .wr_cnt_out(wr_cnt_out)
  );

  // ---------------- reference model ----------------
  logic [7:0] m_mem  [256];
  logic [2:0] m_type [4];
  logic [7:0] m_addr [4];
  logic [7:0] m_aggr [4];
  logic [2:0] m_bit  [4];
  int         m_rd, m_wr;
  logic [7:0] m_data;
  logic       m_vld;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    logic [7:0] d;
    d = m_mem[a];
    for (int i = 0; i < 4; i++) begin
      if (m_addr[i] == a && m_type[i] == 3'd1) d[m_bit[i]] = 1'b0;
      if (m_addr[i] == a && m_type[i] == 3'd2) d[m_bit[i]] = 1'b1;
    end
    return d;
  endfunction

  function automatic bit m_cf_fires(input int i, input logic [7:0] a,
                                    input logic [7:0] old_v, input logic [7:0] new_v);
    return (m_type[i] == 3'd5) && (m_aggr[i] == a) && (m_aggr[i] != m_addr[i]) &&
           (old_v[m_bit[i]] != new_v[m_bit[i]]);
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] old_v, v, vic;
    bit hit;
    old_v = m_mem[a];
    v = d;
    for (int i = 0; i < 4; i++) begin
      if (m_addr[i] == a) begin
        case (m_type[i])
          3'd1: v[m_bit[i]] = 1'b0;
          3'd2: v[m_bit[i]] = 1'b1;
          3'd3: if (old_v[m_bit[i]] == 1'b0 && v[m_bit[i]] == 1'b1) v[m_bit[i]] = 1'b0;
          3'd4: if (old_v[m_bit[i]] == 1'b1 && v[m_bit[i]] == 1'b0) v[m_bit[i]] = 1'b1;
          default: ;
        endcase
      end
    end
    m_mem[a] = v;
    hit = 0;
    vic = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (m_cf_fires(i, a, old_v, v)) begin
        hit = 1;
        vic = m_addr[i];
      end
    end
    if (hit) begin
      for (int i = 0; i < 4; i++) begin
        if (m_cf_fires(i, a, old_v, v) && m_addr[i] == vic) m_mem[vic][m_bit[i]] = ~m_mem[vic][m_bit[i]];
      end
    end
  endtask

  task automatic m_step(input logic rd_op, input logic wr_op, input logic [7:0] a, input logic [7:0] d);
    m_vld = rd_op;
    if (rd_op) begin
      m_data = m_read(a);
      if (m_rd < 65535) m_rd++;
    end
    if (wr_op) begin
      m_write(a, d);
      if (m_wr < 65535) m_wr++;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_junk();
    test_en_in = 1'($urandom);
    tcs_in = 2'($urandom); tas_in = 8'($urandom); tds_in = 8'($urandom);
    fn_re_in = 1'($urandom); fn_we_in = 1'($urandom);
    fn_addr_in = 8'($urandom); fn_data_in = 8'($urandom);
  endtask

  task automatic do_op(input logic te, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    drive_junk();
    test_en_in = te;
    if (te) begin
      tcs_in = op; tas_in = a; tds_in = d;
    end else begin
      fn_re_in = op[0]; fn_we_in = op[1]; fn_addr_in = a; fn_data_in = d;
    end
    @(posedge clk); #1;
    m_step(op[0], op[1], a, d);
  endtask

  task automatic op_exp(input string nm, input logic te, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] d, input logic ev, input logic [7:0] eq);
    do_op(te, op, a, d);
    chk({nm, "_vld"}, mem_vld_out, ev);
    chk({nm, "_data"}, mem_data_out, eq);
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_vld"}, mem_vld_out, m_vld);
    chk({nm, "_data"}, mem_data_out, m_data);
    chk({nm, "_rdcnt"}, rd_cnt_out, m_rd);
    chk({nm, "_wrcnt"}, wr_cnt_out, m_wr);
  endtask

  task automatic set_fault(input int idx, input logic [2:0] ty, input logic [7:0] a,
                           input logic [2:0] b, input logic [7:0] g);
    test_en_in = 1'b1; tcs_in = 2'b00;
    flt_we_in = 1'b1; flt_idx_in = 2'(idx); flt_type_in = ty;
    flt_addr_in = a; flt_bit_in = b; flt_aggr_in = g;
    @(posedge clk); #1;
    flt_we_in = 1'b0;
    m_type[idx] = ty; m_addr[idx] = a; m_bit[idx] = b; m_aggr[idx] = g;
    m_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; flt_we_in = 1'b0;
    test_en_in = 1'b1; tcs_in = 2'b00; fn_re_in = 1'b0; fn_we_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      m_type[i] = 3'd0; m_addr[i] = 8'h00; m_bit[i] = 3'd0; m_aggr[i] = 8'h00;
    end
    m_rd = 0; m_wr = 0; m_data = 8'h00; m_vld = 1'b0;
  endtask

  // Counts cycles with busy high under random (ignored) traffic.
  task automatic wait_init(input string nm);
    int n;
    bit saw;
    n = 0;
    saw = 0;
    while (busy_out === 1'b1 && n < 1000) begin
      n++;
      drive_junk();
      @(posedge clk); #1;
      if (mem_vld_out !== 1'b0) saw = 1;
    end
    chk({nm, "_busy_len"}, n, 256);
    chk({nm, "_no_vld"}, {31'd0, saw}, 0);
    chk({nm, "_rdcnt0"}, rd_cnt_out, 0);
    chk({nm, "_wrcnt0"}, wr_cnt_out, 0);
  endtask

  typedef struct {
    logic       te;
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] data;
    logic       vld;
    logic [7:0] q;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 2'b01, 8'h00, 8'h00, 1'b1, 8'h00};
    tbl[1] = '{1'b1, 2'b01, 8'hFF, 8'h00, 1'b1, 8'h00};
    tbl[2] = '{1'b1, 2'b10, 8'h10, 8'h5A, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 2'b01, 8'h10, 8'h00, 1'b1, 8'h5A};
    tbl[4] = '{1'b1, 2'b11, 8'h10, 8'hA5, 1'b1, 8'h5A};
    tbl[5] = '{1'b1, 2'b01, 8'h10, 8'h00, 1'b1, 8'hA5};

    flt_idx_in = 2'd0; flt_type_in = 3'd0; flt_addr_in = 8'h00; flt_bit_in = 3'd0; flt_aggr_in = 8'h00;
    tas_in = 8'h00; tds_in = 8'h00; fn_addr_in = 8'h00; fn_data_in = 8'h00;
    do_reset();

    // reset state
    chk("rst_vld", mem_vld_out, 0);
    chk("rst_data", mem_data_out, 0);
    chk("rst_busy", busy_out, 1);
    wait_init("init");

    // directed table
    foreach (tbl[i]) begin
      op_exp($sformatf("tbl%0d", i), tbl[i].te, tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].vld, tbl[i].q);
    end
    chk("tbl_rdcnt", rd_cnt_out, 5);
    chk("tbl_wrcnt", wr_cnt_out, 2);

    // stuck-at
    set_fault(0, 3'd2, 8'h20, 3'd0, 8'h00);
    op_exp("sa1_wr", 1'b1, 2'b10, 8'h20, 8'h00, 1'b0, 8'hA5);
    op_exp("sa1_rd", 1'b1, 2'b01, 8'h20, 8'h00, 1'b1, 8'h01);
    set_fault(1, 3'd1, 8'h20, 3'd7, 8'h00);
    op_exp("sa0_wr", 1'b1, 2'b10, 8'h20, 8'hFF, 1'b0, 8'h01);
    op_exp("sa0_rd", 1'b1, 2'b01, 8'h20, 8'h00, 1'b1, 8'h7F);
    // transition faults
    set_fault(2, 3'd3, 8'h30, 3'd3, 8'h00);
    op_exp("tfu_w0", 1'b1, 2'b10, 8'h30, 8'h00, 1'b0, 8'h7F);
    op_exp("tfu_w1", 1'b1, 2'b10, 8'h30, 8'h08, 1'b0, 8'h7F);
    op_exp("tfu_rd", 1'b1, 2'b01, 8'h30, 8'h00, 1'b1, 8'h00);
    set_fault(3, 3'd4, 8'h31, 3'd3, 8'h00);
    op_exp("tfd_w1", 1'b1, 2'b10, 8'h31, 8'h08, 1'b0, 8'h00);
    op_exp("tfd_w0", 1'b1, 2'b10, 8'h31, 8'h00, 1'b0, 8'h00);
    op_exp("tfd_rd", 1'b1, 2'b01, 8'h31, 8'h00, 1'b1, 8'h08);
    // coupling fault
    set_fault(0, 3'd5, 8'h41, 3'd2, 8'h40);
    op_exp("cf_wv", 1'b1, 2'b10, 8'h41, 8'h00, 1'b0, 8'h08);
    op_exp("cf_wa", 1'b1, 2'b10, 8'h40, 8'h04, 1'b0, 8'h08);
    op_exp("cf_rd1", 1'b1, 2'b01, 8'h41, 8'h00, 1'b1, 8'h04);
    op_exp("cf_wa2", 1'b1, 2'b10, 8'h40, 8'h04, 1'b0, 8'h04);
    op_exp("cf_rd2", 1'b1, 2'b01, 8'h41, 8'h00, 1'b1, 8'h04);
    // coupling with aggressor == victim is ignored; type 6 behaves as NONE
    set_fault(0, 3'd5, 8'h50, 3'd1, 8'h50);
    op_exp("cf_self_w", 1'b1, 2'b10, 8'h50, 8'h02, 1'b0, 8'h04);
    op_exp("cf_self_r", 1'b1, 2'b01, 8'h50, 8'h00, 1'b1, 8'h02);
    set_fault(1, 3'd6, 8'h20, 3'd7, 8'h00);
    op_exp("ft6_w", 1'b1, 2'b10, 8'h20, 8'hFF, 1'b0, 8'h02);
    op_exp("ft6_r", 1'b1, 2'b01, 8'h20, 8'h00, 1'b1, 8'hFF);

    // port switch on consecutive cycles: BIST read then functional read
    op_exp("sw_bist", 1'b1, 2'b01, 8'h10, 8'h00, 1'b1, 8'hA5);
    op_exp("sw_fn", 1'b0, 2'b01, 8'h41, 8'h00, 1'b1, 8'h04);
    op_exp("sw_fn_wr", 1'b0, 2'b10, 8'h41, 8'h3C, 1'b0, 8'h04);
    op_exp("sw_bist_rd", 1'b1, 2'b01, 8'h41, 8'h00, 1'b1, 8'h3C);

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        set_fault(int'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  8'(8'h20 + $urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  8'(8'h20 + $urandom_range(0, 7)));
      end else begin
        do_op(1'($urandom), 2'($urandom), 8'(8'h20 + $urandom_range(0, 7)), 8'($urandom));
        chk_model("rnd");
      end
    end

    // reset asserted part-way through INIT restarts the full sweep
    do_reset();
    for (int k = 0; k < 99; k++) begin
      drive_junk();
      @(posedge clk); #1;
    end
    chk("mid_busy", busy_out, 1);
    do_reset();
    wait_init("mid");
    do_op(1'b1, 2'b01, 8'h20, 8'h00);
    chk_model("post_init");
    do_op(1'b0, 2'b11, 8'h22, 8'h99);
    chk_model("post_rdwr");
    do_op(1'b1, 2'b01, 8'h22, 8'h00);
    chk_model("post_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
